// File: rtl/jt7759_rom_pkg.sv
// Shared widths, FSM states and line record for the JT7759 ROM bridge.
// JT7759_PREFETCH_EN selects the two-line prefetching build.
package jt7759_rom_pkg;

    localparam int LINE_AW    = 15;
    localparam int BYTE_SEL_W = 2;
    localparam int LINE_DW    = 32;
    localparam int ROM_AW     = LINE_AW + BYTE_SEL_W;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        LOOKUP   = 5'b00010,
        FETCH    = 5'b00100,
        SERVE    = 5'b01000,
        PREFETCH = 5'b10000
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [LINE_AW-1:0] tag;
        logic [LINE_DW-1:0] data;
    } line_t;

    function automatic logic [7:0] pick_byte(
        input logic [LINE_DW-1:0]    w,
        input logic [BYTE_SEL_W-1:0] s
    );
        logic [7:0] b;
        unique case (s)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jt7759_rom_line.sv
// One tagged 32-bit line of the ROM bridge buffer.
// Instantiated once, or twice when JT7759_PREFETCH_EN is defined.
module jt7759_rom_line
    import jt7759_rom_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_we,
    input  logic [LINE_AW-1:0] i_tag,
    input  logic [LINE_DW-1:0] i_data,
    input  logic [LINE_AW-1:0] i_cmp_tag,
    output logic               o_hit,
    output logic [LINE_DW-1:0] o_data
);

    line_t r_line;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line <= '0;
        end else if (i_clr) begin
            r_line.valid <= 1'b0;
        end else if (i_we) begin
            r_line.valid <= 1'b1;
            r_line.tag   <= i_tag;
            r_line.data  <= i_data;
        end
    end

    assign o_hit  = r_line.valid && (r_line.tag == i_cmp_tag);
    assign o_data = r_line.data;

endmodule

// File: rtl/jt7759_rom_bridge.sv
// Byte-wide ROM responder for JT7759 backed by a tagged line buffer.
// Define JT7759_PREFETCH_EN for two LRU lines plus next-line prefetch.
module jt7759_rom_bridge
    import jt7759_rom_pkg::*;
(
    input  logic                rst,
    input  logic                clk,
    input  logic                rom_cs,
    input  logic [ROM_AW-1:0]   rom_addr,
    output logic [7:0]          rom_data,
    output logic                rom_ok,
    output logic                ext_cs,
    output logic [LINE_AW-1:0]  ext_addr,
    input  logic [LINE_DW-1:0]  ext_data,
    input  logic                ext_ok
);

`ifdef JT7759_PREFETCH_EN
    localparam int NL = 2;
`else
    localparam int NL = 1;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_cs_d;
    logic [ROM_AW-1:0]   r_addr;
    logic                r_rom_ok;
    logic [7:0]          r_rom_data;
    logic [LINE_AW-1:0]  r_ext_addr;
    logic [LINE_AW-1:0]  w_cmp_tag;
    logic                w_req;
    logic                w_fill;
    logic                w_hit_any;
    logic [LINE_DW-1:0]  w_hit_word;
    logic [NL-1:0]       w_hit;
    logic [NL-1:0]       w_we;
    logic [LINE_DW-1:0]  w_data [NL];

`ifdef JT7759_PREFETCH_EN
    logic                r_lru;
    logic                w_hit_idx;
    logic                r_pf_pend;
    logic [LINE_AW-1:0]  r_pf_addr;
`endif

    assign w_req  = rom_cs && (!r_cs_d || (rom_addr != r_addr));
    assign w_fill = ext_ok && ((r_state == FETCH) || (r_state == PREFETCH));

`ifdef JT7759_PREFETCH_EN
    // The compare port probes the prefetch target while serving.
    assign w_cmp_tag = (r_state == SERVE) ? r_pf_addr
                                          : r_addr[ROM_AW-1:BYTE_SEL_W];
    assign w_we[0]   = w_fill && !r_lru;
    assign w_we[1]   = w_fill && r_lru;
`else
    assign w_cmp_tag = r_addr[ROM_AW-1:BYTE_SEL_W];
    assign w_we[0]   = w_fill;
`endif

    for (genvar g = 0; g < NL; g++) begin : g_line
        jt7759_rom_line u_line (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_clr     (1'b0),
            .i_we      (w_we[g]),
            .i_tag     (r_ext_addr),
            .i_data    (ext_data),
            .i_cmp_tag (w_cmp_tag),
            .o_hit     (w_hit[g]),
            .o_data    (w_data[g])
        );
    end

    assign w_hit_any = |w_hit;

    always_comb begin
        w_hit_word = '0;
        for (int i = 0; i < NL; i++) begin
            if (w_hit[i]) w_hit_word = w_data[i];
        end
    end

`ifdef JT7759_PREFETCH_EN
    assign w_hit_idx = w_hit[1];
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (w_req)          w_next = LOOKUP;
                else if (!rom_cs)   w_next = IDLE;
                else if (w_hit_any) w_next = SERVE;
                else                w_next = FETCH;
            end
            FETCH: begin
                if (ext_ok) w_next = LOOKUP;
            end
            SERVE: begin
                if (w_req)        w_next = LOOKUP;
                else if (!rom_cs) w_next = IDLE;
`ifdef JT7759_PREFETCH_EN
                else if (r_pf_pend && !w_hit_any) w_next = PREFETCH;
`endif
            end
            PREFETCH: begin
                if (ext_ok) w_next = LOOKUP;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_d     <= 1'b0;
            r_addr     <= '0;
            r_rom_ok   <= 1'b0;
            r_rom_data <= '0;
            r_ext_addr <= '0;
        end else begin
            r_cs_d <= rom_cs;
            if (w_req) r_addr <= rom_addr;
            if (w_req || !rom_cs) begin
                r_rom_ok <= 1'b0;
            end else if (r_state == LOOKUP && w_hit_any) begin
                r_rom_ok   <= 1'b1;
                r_rom_data <= pick_byte(w_hit_word, r_addr[BYTE_SEL_W-1:0]);
            end
            if (r_state == LOOKUP && w_next == FETCH)
                r_ext_addr <= r_addr[ROM_AW-1:BYTE_SEL_W];
`ifdef JT7759_PREFETCH_EN
            else if (r_state == SERVE && w_next == PREFETCH)
                r_ext_addr <= r_pf_addr;
`endif
        end
    end

`ifdef JT7759_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lru     <= 1'b0;
            r_pf_pend <= 1'b0;
            r_pf_addr <= '0;
        end else begin
            if (w_fill) r_lru <= !r_lru;
            else if (r_state == LOOKUP && w_hit_any) r_lru <= !w_hit_idx;
            // Only demand fills arm a prefetch; serving launches or skips it.
            if (r_state == FETCH && ext_ok) begin
                r_pf_pend <= 1'b1;
                r_pf_addr <= r_ext_addr + 1'b1;
            end else if (r_state == SERVE && !w_req && rom_cs) begin
                r_pf_pend <= 1'b0;
            end
        end
    end
`endif

    assign rom_ok   = r_rom_ok;
    assign rom_data = r_rom_data;
    assign ext_cs   = (r_state == FETCH) || (r_state == PREFETCH);
    assign ext_addr = r_ext_addr;

endmodule

// File: doc/jt7759_rom_bridge.md
# jt7759_rom_bridge

ROM-side responder for the JT7759 sequencer's byte-wide ROM port. It answers each `rom_cs`/`rom_addr` request with `rom_data`/`rom_ok` from a small tagged line buffer. Misses are refilled from a 32-bit external memory port through a req/ok handshake. It sits between the JT7759 top level and the system SDRAM/BRAM arbiter, so the sequencer never stalls on a wide-memory access it could serve locally.

## Interface
- No parameters; widths are fixed constants in the package.
- `rst` in 1: asynchronous, active-high reset.
- `clk` in 1: single system clock.
- `rom_cs` in 1: sequencer read strobe. The sequencer drops it for one cycle between requests.
- `rom_addr` in 17: byte address.
- `rom_data` out 8: byte at `rom_addr`. Valid while `rom_ok`=1.
- `rom_ok` out 1: data valid for the current `rom_cs`/`rom_addr`.
- `ext_cs` out 1: external line request.
- `ext_addr` out 15: external 32-bit word (line) address.
- `ext_data` in 32: line data. Byte 0 is `ext_data[7:0]`.
- `ext_ok` in 1: external memory accept/data strobe.

## Operation
- Line = 4 bytes. Tag = `rom_addr[16:2]`. Byte select = `rom_addr[1:0]`.
- Request cycle R: `rom_cs`=1 and (`rom_cs` was 0 last cycle, or `rom_addr` differs from the latched request address).
- End of R: latch the address and force `rom_ok` to 0.
- FSM states:
  - IDLE: waits for R, then goes to LOOKUP.
  - LOOKUP: compares the tag against all valid lines. On a hit, go to SERVE. On a miss, go to FETCH.
  - FETCH: `ext_cs`=1 with `ext_addr`=latched tag. On `ext_ok`, write the line, set it valid, go to LOOKUP.
  - SERVE: drives `rom_data` and `rom_ok`=1. On a new R, go to LOOKUP. On `rom_cs`=0, go to IDLE.
- `rom_cs`=0 in any cycle: `rom_ok` is 0 the next cycle. `rom_data` holds its last value.
- A new R while in FETCH:
  - The external transaction is never aborted; it completes and fills its line.
  - The FSM then re-enters LOOKUP with the newest latched address.
  - Stale data is never presented with `rom_ok`=1.
- Replacement: single-line build overwrites the only line. Two-line build is covered under Configuration.
- Reset mid-fetch: `ext_cs` drops asynchronously and all valid bits clear. Any late `ext_ok` is ignored because the FSM is in IDLE.

## Timing
- Reset values: `rom_ok`=0, `rom_data`=0, `ext_cs`=0, `ext_addr`=0, all valid bits 0, state IDLE.
- Hit latency: R at cycle t gives `rom_ok`=1 in cycle t+2.
- Miss latency:
  - `ext_cs` rises in cycle t+2.
  - With `ext_ok` sampled high in cycle E, `rom_ok`=1 in cycle E+2 (E+1 is LOOKUP).
- External handshake:
  - `ext_cs` and `ext_addr` stay stable from assertion until `ext_ok` is sampled high.
  - `ext_data` is captured in that same cycle.
  - `ext_cs` is 0 in cycle E+1.
  - Back-to-back requests therefore always have at least one idle cycle.
- `ext_ok` while `ext_cs`=0: ignored.
- Same-address re-request after a `rom_cs` low pulse: treated as R. It is served as a hit at t+2.

## Configuration
- `JT7759_PREFETCH_EN` defined:
  - Two lines with LRU replacement.
  - After filling line N on a demand miss, the bridge issues one background fetch of line N+1. The address wraps from 0x7FFF to 0x0000.
  - Prefetch state: PREFETCH, entered from SERVE with `ext_cs`=1.
  - A demand miss arriving during PREFETCH waits for that fetch to complete, then goes through LOOKUP again.
  - The prefetched line may satisfy the new request.
  - A prefetch is skipped if line N+1 is already valid.
- Undefined: one line, no PREFETCH state, and `ext_cs` is only ever asserted for demand misses.

## Structure
- Package `jt7759_rom_pkg` holds:
  - one-hot state constants IDLE/LOOKUP/FETCH/SERVE/PREFETCH;
  - `LINE_AW`=15, `BYTE_SEL_W`=2, `LINE_DW`=32;
  - the tag/line record typedef.
- Sub-module `jt7759_rom_line` holds one line:
  - ports for tag, valid, 32-bit data, write enable, clear, and hit output for a given tag;
  - instantiated once, or twice with `JT7759_PREFETCH_EN`.

## Test plan
- Reset, then request 0x00005 with `ext_ok` returning 0x44332211 two cycles after `ext_cs`: `ext_addr`=0x0001 and `rom_data`=0x22 with `rom_ok`=1 at E+2. Then `rom_addr` 0x00007 after a one-cycle `rom_cs` low: `rom_data`=0x44 at t+2 with no `ext_cs`.
- Sequencer-style stream 0x00100..0x0010F, one request per 4 cycles: exactly 4 external fetches (0x40..0x43), with every byte matching the model.
- Address change to 0x1FFF0 during an outstanding fetch of 0x00000: that fetch completes, then a second `ext_cs` goes out with `ext_addr`=0x7FFC, and `rom_ok` never pulses with 0x00000 data.
- `JT7759_PREFETCH_EN`: miss on 0x1FFFC gives a demand fetch of 0x7FFF, then a prefetch of 0x0000. A request to 0x00001 then hits with zero further `ext_cs`.
- Async `rst` asserted while `ext_cs`=1: outputs at reset values immediately, and an `ext_ok` pulse afterward causes no state change.
- `ext_ok` stuck low for 1000 cycles: `ext_cs` and `ext_addr` stay stable and `rom_ok` stays 0 throughout.
